// File: rtl/hospital_rover_router_if.sv
// hospital_rover_router_if: request handshake and rover status bundle
interface hospital_rover_router_if #(
  parameter int LOC_W = 3,
  parameter int QDEPTH = 4
);
  logic move_switch, req_valid, req_ready, recall, moving, dir, arrived, req_err;
  logic [LOC_W-1:0] req_dest, current_loc, dest_loc;
  logic [$clog2(QDEPTH):0] q_count;
  modport slave(
    input move_switch, req_valid, req_dest, recall,
    output req_ready, current_loc, dest_loc, moving, dir, arrived, req_err, q_count
  );
  modport master(
    output move_switch, req_valid, req_dest, recall,
    input req_ready, current_loc, dest_loc, moving, dir, arrived, req_err, q_count
  );
endinterface

// File: rtl/hospital_rover_router.sv
// hospital_rover_router: queued shortest-path ring rover controller with dwell and emergency recall
module hospital_rover_router #(
  parameter int NUM_ROOMS = 8,
  parameter int LOC_W = 3,
  parameter int QDEPTH = 4,
  parameter int HOP_CYCLES = 2,
  parameter int DWELL_CYCLES = 3
) (
  input logic clk,
  input logic reset,
  hospital_rover_router_if.slave bus
);
  localparam int QW = $clog2(QDEPTH);
  localparam int HW = HOP_CYCLES > 1 ? $clog2(HOP_CYCLES) : 1;
  localparam int DW = DWELL_CYCLES > 1 ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [LOC_W:0] NR = (LOC_W+1)'(NUM_ROOMS);
  localparam logic [LOC_W-1:0] LAST = LOC_W'(NUM_ROOMS - 1);
  localparam logic [HW-1:0] HOP_LAST = HW'(HOP_CYCLES - 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, TRAVEL, DWELL, RECALL} state_t;
  state_t state_q, state_d;
  logic [LOC_W-1:0] cur_q, cur_d, dest_q, dest_d, step_loc, head;
  logic dir_q, dir_d, arrived_q, arrived_d, err_q, err_d;
  logic [HW-1:0] hop_q, hop_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [QW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [QW:0] cnt_q, cnt_d;
  logic [LOC_W-1:0] mem [QDEPTH];
  logic bad, push, pop, flush;
  function automatic logic go_up(input logic [LOC_W-1:0] to, input logic [LOC_W-1:0] from);
    logic [LOC_W:0] d_up;
    d_up = {1'b0, to} + (to >= from ? (LOC_W+1)'(0) : NR) - {1'b0, from};
    return d_up <= NR - d_up;
  endfunction
  assign head = mem[rp_q];
  assign step_loc = dir_q ? (cur_q == LAST ? '0 : cur_q + LOC_W'(1)) : (cur_q == '0 ? LAST : cur_q - LOC_W'(1));
  assign bad = {1'b0, bus.req_dest} >= NR;
  assign bus.req_ready = cnt_q != (QW+1)'(QDEPTH) && !bus.recall && !reset;
  assign push = bus.req_valid && bus.req_ready && !bad;
  always_comb begin
    state_d = state_q;
    cur_d = cur_q;
    dest_d = dest_q;
    dir_d = dir_q;
    hop_d = hop_q;
    dwell_d = dwell_q;
    arrived_d = 1'b0;
    pop = 1'b0;
    flush = 1'b0;
    if (bus.recall && state_q != RECALL) begin
      flush = 1'b1;
      dest_d = '0;
      dir_d = go_up('0, cur_q);
      hop_d = '0;
      arrived_d = cur_q == '0;
      state_d = arrived_d ? IDLE : RECALL;
    end else if (state_q == IDLE && cnt_q != '0) begin
      pop = 1'b1;
      dest_d = head;
      dir_d = go_up(head, cur_q);
      hop_d = '0;
      dwell_d = '0;
      arrived_d = head == cur_q;
      state_d = arrived_d ? DWELL : TRAVEL;
    end else if (state_q == DWELL) begin
      dwell_d = dwell_q + DW'(1);
      state_d = dwell_q == DWELL_LAST ? IDLE : DWELL;
    end else if ((state_q == TRAVEL || state_q == RECALL) && bus.move_switch) begin
      hop_d = hop_q == HOP_LAST ? '0 : hop_q + HW'(1);
      if (hop_q == HOP_LAST) begin
        cur_d = step_loc;
        dwell_d = '0;
        arrived_d = step_loc == dest_q;
        state_d = !arrived_d ? state_q : state_q == TRAVEL ? DWELL : IDLE;
      end
    end
    wp_d = flush ? '0 : wp_q + QW'(push);
    rp_d = flush ? '0 : rp_q + QW'(pop);
    cnt_d = flush ? '0 : cnt_q + (QW+1)'(push) - (QW+1)'(pop);
    err_d = bus.req_valid && bus.req_ready && bad;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cur_q <= '0;
      dest_q <= '0;
      dir_q <= 1'b0;
      hop_q <= '0;
      dwell_q <= '0;
      arrived_q <= 1'b0;
      err_q <= 1'b0;
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cur_q <= cur_d;
      dest_q <= dest_d;
      dir_q <= dir_d;
      hop_q <= hop_d;
      dwell_q <= dwell_d;
      arrived_q <= arrived_d;
      err_q <= err_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) if (push) mem[wp_q] <= bus.req_dest;
  assign bus.current_loc = cur_q;
  assign bus.dest_loc = dest_q;
  assign bus.moving = state_q == TRAVEL || state_q == RECALL;
  assign bus.dir = dir_q;
  assign bus.arrived = arrived_q;
  assign bus.req_err = err_q;
  assign bus.q_count = cnt_q;
endmodule
